// File: rtl/decoder_n_pipe_if.sv
// Handshake bundle for decoder_n_pipe: code input stream and one-hot output stream.
// The slave modport is the decoder side, the master modport is the producer/consumer side.
interface decoder_n_pipe_if #(
  parameter int IN_W    = 3,
  parameter int NUM_OUT = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    data;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OUT-1:0] out;

  modport master (
    output in_valid, data, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, data, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/decoder_n_pipe.sv
// Pipelined N-to-M one-hot decoder with valid/ready on both sides, a 2-entry
// output buffer and a self-driven sweep mode that walks every output line.
// Optional build macro: DEC_RANGE_ERR_EN -- out-of-range host codes are
// discarded and flagged on err instead of being emitted as an all-zero word.
module decoder_n_pipe #(
  parameter int IN_W       = 3,
  parameter int NUM_OUT    = 8,
  parameter int SWEEP_HOLD = 1
) (
  input  logic            clk,
  input  logic            rst,
  decoder_n_pipe_if.slave bus,
  input  logic            mode,
  input  logic            sweep_start,
  output logic            busy,
  output logic            sweep_done
`ifdef DEC_RANGE_ERR_EN
  ,
  output logic            err
`endif
);

  localparam int HOLD_W = (SWEEP_HOLD > 1) ? $clog2(SWEEP_HOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  // Two-slot buffer kept as head/tail so the head register drives out directly.
  logic [NUM_OUT-1:0] head_q, head_d;
  logic [NUM_OUT-1:0] tail_q, tail_d;
  logic               head_vld_q, head_vld_d;
  logic               tail_vld_q, tail_vld_d;
  logic [IN_W-1:0]    code_q, code_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               sweep_done_q, sweep_done_d;

  logic               fifo_full;
  logic               in_ready_c;
  logic               host_acc;
  logic               host_push;
  logic               sweep_push;
  logic               push;
  logic               pop;
  logic [NUM_OUT-1:0] push_word;

`ifdef DEC_RANGE_ERR_EN
  logic               err_q, err_d;
  logic               in_range;
`endif

  // Codes at or above NUM_OUT match no line and decode to all zeros.
  function automatic logic [NUM_OUT-1:0] decode(input logic [IN_W-1:0] code);
    logic [NUM_OUT-1:0] w;
    w = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if ({1'b0, code} == (IN_W+1)'(k)) w[k] = 1'b1;
    end
    return w;
  endfunction

  // Handshake qualification and the word to be enqueued this cycle.
  always_comb begin
    fifo_full  = tail_vld_q;
    in_ready_c = !rst && (state_q == S_IDLE) && !fifo_full;
    host_acc   = bus.in_valid && in_ready_c;
    pop        = head_vld_q && bus.out_ready;
`ifdef DEC_RANGE_ERR_EN
    in_range   = ({1'b0, bus.data} < (IN_W+1)'(NUM_OUT));
    host_push  = host_acc && in_range;
    err_d      = host_acc && !in_range;
`else
    host_push  = host_acc;
`endif
    sweep_push = (state_q == S_SWEEP) && !fifo_full && (hold_q == '0);
    push       = host_push || sweep_push;
    push_word  = sweep_push ? decode(code_q) : decode(bus.data);
  end

  // Buffer update: pop shifts tail into head, then push fills the first free slot.
  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    tail_d     = tail_q;
    tail_vld_d = tail_vld_q;
    if (pop) begin
      head_d     = tail_q;
      head_vld_d = tail_vld_q;
      tail_d     = '0;
      tail_vld_d = 1'b0;
    end
    if (push) begin
      if (!head_vld_d) begin
        head_d     = push_word;
        head_vld_d = 1'b1;
      end else begin
        tail_d     = push_word;
        tail_vld_d = 1'b1;
      end
    end
  end

  // Sweep sequencer: next state, code counter and hold timer.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    hold_d       = hold_q;
    sweep_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sweep_start && mode && !head_vld_q) begin
          state_d = S_SWEEP;
          code_d  = '0;
          hold_d  = '0;
        end
      end
      S_SWEEP: begin
        if (sweep_push) begin
          hold_d = HOLD_W'(SWEEP_HOLD - 1);
          if (code_q == IN_W'(NUM_OUT - 1)) begin
            state_d = S_DRAIN;
          end else begin
            code_d = code_q + 1'b1;
          end
        end else if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_DRAIN: begin
        // Done on the edge that leaves the buffer empty.
        if (!head_vld_d) begin
          state_d      = S_IDLE;
          sweep_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and buffer registers; reset flushes the buffer and aborts any sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      head_vld_q   <= 1'b0;
      tail_vld_q   <= 1'b0;
      code_q       <= '0;
      hold_q       <= '0;
      sweep_done_q <= 1'b0;
`ifdef DEC_RANGE_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      head_vld_q   <= head_vld_d;
      tail_vld_q   <= tail_vld_d;
      code_q       <= code_d;
      hold_q       <= hold_d;
      sweep_done_q <= sweep_done_d;
`ifdef DEC_RANGE_ERR_EN
      err_q        <= err_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = head_vld_q;
  assign bus.out       = head_q;
  assign busy          = (state_q != S_IDLE);
  assign sweep_done    = sweep_done_q;
`ifdef DEC_RANGE_ERR_EN
  assign err           = err_q;
`endif

endmodule

// File: tb/tb_decoder_n_pipe.sv
// Bench for decoder_n_pipe: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_decoder_n_pipe;
  localparam int IN_W       = 3;
  localparam int NUM_OUT    = 6;
  localparam int SWEEP_HOLD = 2;
`ifdef DEC_RANGE_ERR_EN
  localparam bit ERR_EN = 1'b1;
  logic err;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0;
  logic sweep_start = 1'b0;
  logic busy;
  logic sweep_done;

  decoder_n_pipe_if #(.IN_W(IN_W), .NUM_OUT(NUM_OUT)) bus ();

  decoder_n_pipe #(
    .IN_W(IN_W), .NUM_OUT(NUM_OUT), .SWEEP_HOLD(SWEEP_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .mode(mode),
    .sweep_start(sweep_start),
    .busy(busy),
    .sweep_done(sweep_done)
`ifdef DEC_RANGE_ERR_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [NUM_OUT-1:0] word_of(input int c);
    logic [NUM_OUT-1:0] one;
    one = 1;
    return (c < NUM_OUT) ? (one << c) : '0;
  endfunction

  // Reference model: a queue of pending words plus sweep bookkeeping.
  logic [NUM_OUT-1:0] q[$];
  bit m_sw, m_dr, exp_done, exp_err, armed;
  int m_code, m_hold, sz;
  bit idle, pop, hpush, spush, was_dr;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_sw = 0; m_dr = 0; m_code = 0; m_hold = 0;
      exp_done = 0; exp_err = 0; armed = 1;
    end else if (armed) begin
      sz = q.size();
      idle = !m_sw && !m_dr;
      was_dr = m_dr;
      pop = (sz > 0) && bus.out_ready;
      hpush = idle && bus.in_valid && (sz < 2);
      spush = m_sw && (sz < 2) && (m_hold == 0);
      exp_done = 0; exp_err = 0;
      if (pop) void'(q.pop_front());
      if (hpush) begin
        if (ERR_EN && int'(bus.data) >= NUM_OUT) exp_err = 1;
        else q.push_back(word_of(int'(bus.data)));
      end
      if (idle && sweep_start && mode && sz == 0) begin
        m_sw = 1; m_code = 0; m_hold = 0;
      end else if (m_sw) begin
        if (spush) begin
          q.push_back(word_of(m_code));
          m_hold = SWEEP_HOLD - 1;
          if (m_code == NUM_OUT - 1) begin m_sw = 0; m_dr = 1; end
          else m_code++;
        end else if (m_hold > 0) begin
          m_hold--;
        end
      end
      if (was_dr && q.size() == 0) begin m_dr = 0; exp_done = 1; end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!rst && !m_sw && !m_dr && q.size() < 2));
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("out", 32'(bus.out), (q.size() > 0) ? 32'(q[0]) : 32'd0);
      chk("busy", 32'(busy), 32'(m_sw || m_dr));
      chk("sweep_done", 32'(sweep_done), 32'(exp_done));
`ifdef DEC_RANGE_ERR_EN
      chk("err", 32'(err), 32'(exp_err));
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  int n_words, n_done, guard;
  logic [NUM_OUT-1:0] seen[$];
  bit hit;

  initial begin
    bus.in_valid = 0; bus.data = '0; bus.out_ready = 1;

    // Reset held two cycles.
    repeat (2) step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 0;
    step();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Direct stream, back-to-back, one cycle latency.
    for (int c = 0; c < NUM_OUT; c++) begin
      bus.in_valid = 1; bus.data = IN_W'(c);
      step();
      chk("stream_valid", 32'(bus.out_valid), 32'd1);
      chk("stream_out", 32'(bus.out), 32'd1 << c);
    end
    bus.in_valid = 0;
    step();

    // Out-of-range host code.
    bus.in_valid = 1; bus.data = 3'd7;
    step();
    bus.in_valid = 0;
`ifdef DEC_RANGE_ERR_EN
    chk("oor_err", 32'(err), 32'd1);
    chk("oor_no_valid", 32'(bus.out_valid), 32'd0);
`else
    chk("oor_valid", 32'(bus.out_valid), 32'd1);
    chk("oor_zero", 32'(bus.out), 32'd0);
`endif
    step();

    // Backpressure: third code refused while buffer is full.
    bus.out_ready = 0;
    bus.in_valid = 1; bus.data = 3'd5;
    step();
    bus.data = 3'd2;
    step();
    chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head", 32'(bus.out), 32'b100000);
    bus.data = 3'd4;
    step();
    chk("bp_hold", 32'(bus.out), 32'b100000);
    chk("bp_still_full", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1;
    step();
    chk("bp_second", 32'(bus.out), 32'b000100);
    step();
    chk("bp_third", 32'(bus.out), 32'b010000);
    bus.in_valid = 0;
    step();

    // Full sweep with hold of two cycles per code.
    mode = 1; sweep_start = 1;
    step();
    sweep_start = 0; mode = 0;
    seen.delete(); n_done = 0; guard = 0;
    while (guard < 80 && (busy || seen.size() == 0)) begin
      step();
      if (bus.out_valid) seen.push_back(bus.out);
      if (sweep_done) n_done++;
      if (busy) chk("sweep_in_ready", 32'(bus.in_ready), 32'd0);
      guard++;
    end
    chk("sweep_timeout", 32'(guard < 80), 32'd1);
    chk("sweep_count", 32'(seen.size()), 32'(NUM_OUT));
    for (int i = 0; i < seen.size(); i++) chk("sweep_word", 32'(seen[i]), 32'd1 << i);
    chk("sweep_done_once", 32'(n_done), 32'd1);
    chk("sweep_idle", 32'(busy), 32'd0);
    step();

    // Reset in the middle of a sweep, then restart from code 0.
    mode = 1; sweep_start = 1;
    step();
    sweep_start = 0;
    hit = 0; guard = 0;
    while (!hit && guard < 40) begin
      step();
      if (bus.out_valid && bus.out == 6'b001000) hit = 1;
      guard++;
    end
    chk("midsweep_reached", 32'(hit), 32'd1);
    rst = 1;
    step();
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(sweep_done), 32'd0);
    rst = 0;
    n_done = 0;
    repeat (3) begin
      step();
      if (sweep_done) n_done++;
    end
    chk("midrst_no_done", 32'(n_done), 32'd0);
    sweep_start = 1;
    step();
    sweep_start = 0;
    hit = 0; guard = 0;
    while (!hit && guard < 10) begin
      step();
      if (bus.out_valid) begin
        hit = 1;
        chk("restart_code0", 32'(bus.out), 32'd1);
      end
      guard++;
    end
    chk("restart_seen", 32'(hit), 32'd1);
    guard = 0;
    while (busy && guard < 60) begin step(); guard++; end
    chk("restart_drain", 32'(busy), 32'd0);
    mode = 0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.data      = IN_W'($urandom_range(0, 7));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      sweep_start   = ($urandom_range(0, 40) == 0);
      mode          = ($urandom_range(0, 1) == 1);
      rst           = ($urandom_range(0, 300) == 0);
      step();
    end
    rst = 0; bus.in_valid = 0; sweep_start = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end
endmodule
